// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC each cycle (increment, branch, call, return, halt)
// and owns the return-address stack and the IDLE/RUN/HALT control state.
module pc_sequencer #(
    parameter int PC_W        = 7,
    parameter int IDX_W       = 6,
    parameter int STACK_DEPTH = 4,
    parameter int START_PC    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             halt_req,
    input  logic [IDX_W-1:0] target_idx,
    output logic [IDX_W-1:0] lut_idx,
    input  logic [PC_W-1:0]  lut_target,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             halted,
    output logic             stack_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SLT_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    logic [1:0]      state;
    logic [SP_W-1:0] sp;
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [PC_W-1:0] pc_inc;
    logic [SLT_W-1:0] push_slot;
    logic [SLT_W-1:0] top_slot;
    logic            stack_full;
    logic            stack_empty;
    logic            act;
    logic            push_en;

    assign lut_idx     = target_idx;
    assign pc_inc      = pc + 1'b1;
    assign push_slot   = SLT_W'(sp);
    assign top_slot    = SLT_W'(sp - 1'b1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign running     = (state == RUN);
    assign halted      = (state == HALT);

    // An active RUN cycle; stall freezes everything including the stack write.
    assign act     = (state == RUN) && !stall;
    assign push_en = act && !halt_req && !ret_en && call_en && !stack_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= START;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state     <= RUN;
                        pc        <= START;
                        sp        <= '0;
                        stack_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            state <= HALT;
                        end else if (ret_en) begin
                            if (stack_empty) begin
                                stack_err <= 1'b1;
                                state     <= HALT;
                            end else begin
                                pc <= stack[top_slot];
                                sp <= sp - 1'b1;
                            end
                        end else if (call_en) begin
                            if (stack_full) begin
                                stack_err <= 1'b1;
                                state     <= HALT;
                            end else begin
                                pc <= lut_target;
                                sp <= sp + 1'b1;
                            end
                        end else if (branch_en && branch_cond) begin
                            pc <= lut_target;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entries are never reset; sp alone guards against reading a stale slot.
    always_ff @(posedge clk) begin
        if (push_en) stack[push_slot] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected outputs are queued per step and checked after the edge.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, stall, branch_en, branch_cond, call_en, ret_en, halt_req;
    logic [5:0] target_idx, lut_idx;
    logic [6:0] lut_target, pc;
    logic       running, halted, stack_err;

    logic [6:0] lut [64];
    assign lut_target = lut[lut_idx];

    typedef struct {
        string      tag;
        logic [6:0] pc;
        logic       run;
        logic       hlt;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_cond(branch_cond), .call_en(call_en),
        .ret_en(ret_en), .halt_req(halt_req), .target_idx(target_idx),
        .lut_idx(lut_idx), .lut_target(lut_target), .pc(pc),
        .running(running), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        cmp({e.tag, ".pc"}, pc, e.pc);
        cmp({e.tag, ".running"}, {6'd0, running}, {6'd0, e.run});
        cmp({e.tag, ".halted"}, {6'd0, halted}, {6'd0, e.hlt});
        cmp({e.tag, ".stack_err"}, {6'd0, stack_err}, {6'd0, e.err});
    endtask

    task automatic drv(input logic s, input logic st, input logic be, input logic bc,
                       input logic ce, input logic re, input logic hr, input logic [5:0] idx);
        start = s; stall = st; branch_en = be; branch_cond = bc;
        call_en = ce; ret_en = re; halt_req = hr; target_idx = idx;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 6'd0);
    endtask

    task automatic step(input string tag, input logic [6:0] epc,
                        input logic er, input logic eh, input logic ee);
        exp_t e;
        sb.push_back('{tag, epc, er, eh, ee});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_all(e);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) lut[i] = 7'(i + 64);
        lut[0] = 7'd10; lut[1] = 7'd20; lut[2] = 7'd30; lut[3] = 7'd40;
        lut[4] = 7'd11; lut[5] = 7'd50; lut[6] = 7'd126; lut[7] = 7'd127;

        idle();
        #12;
        chk_all('{"reset", 7'd0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drv(0, 0, 1, 1, 1, 1, 1, 6'd1); step("idle_ignore", 7'd0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("start",       7'd0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            idle(); step("inc", 7'(i), 1, 0, 0);
        end

        // call/return pair
        drv(0, 0, 0, 0, 1, 0, 0, 6'd4); step("call",     7'd11, 1, 0, 0);
        idle();                          step("inc_call", 7'd12, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("ret",      7'd6,  1, 0, 0);

        drv(0, 0, 1, 1, 0, 0, 0, 6'd0); step("br_taken", 7'd10, 1, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 6'd0); step("br_not",   7'd11, 1, 0, 0);

        // stall wins over call and halt
        drv(0, 1, 0, 0, 1, 0, 0, 6'd5); step("stall_call", 7'd11, 1, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 1, 6'd0); step("stall_halt", 7'd11, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd5); step("call_after", 7'd50, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("ret_after",  7'd12, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("underflow",  7'd12, 0, 1, 1);
        drv(0, 0, 1, 1, 0, 0, 0, 6'd0); step("halt_hold",  7'd12, 0, 1, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("restart1",   7'd0,  1, 0, 0);

        // fill the stack, pop one, refill, then overflow
        drv(0, 0, 0, 0, 1, 0, 0, 6'd1); step("call1", 7'd20, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd2); step("call2", 7'd30, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd3); step("call3", 7'd40, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd5); step("call4", 7'd50, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("ret4",  7'd41, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd5); step("call4b", 7'd50, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd0); step("overflow", 7'd50, 0, 1, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("restart2", 7'd0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("sp_cleared", 7'd0, 0, 1, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("restart3", 7'd0, 1, 0, 0);

        drv(0, 0, 0, 0, 1, 0, 1, 6'd1); step("halt_call", 7'd0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("restart4",  7'd0, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("start_in_run", 7'd1, 1, 0, 0);

        // wrap at 2^PC_W, including a wrapped return address
        drv(0, 0, 1, 1, 0, 0, 0, 6'd6); step("br126", 7'd126, 1, 0, 0);
        idle();                          step("inc127", 7'd127, 1, 0, 0);
        idle();                          step("wrap",   7'd0,   1, 0, 0);
        drv(0, 0, 1, 1, 0, 0, 0, 6'd7); step("br127", 7'd127, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 6'd1); step("call_wrap", 7'd20, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 6'd0); step("ret_wrap",  7'd0,  1, 0, 0);
        idle();                          step("inc_pre_rst", 7'd1, 1, 0, 0);

        // asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1 chk_all('{"async_rst", 7'd0, 1'b0, 1'b0, 1'b0});
        #2 rst_n = 1'b1;
        idle();                          step("post_rst_idle", 7'd0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 6'd0); step("post_rst_start", 7'd0, 1, 0, 0);
        idle();                          step("post_rst_inc", 7'd1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
